mips_mem_responder: RTL and testbench

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/mips_mem_responder_word_ram.sv | 30 +++
 rtl/mips_mem_responder.sv | 107 ++++++++++
 tb/tb_mips_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory responder.
// Holds the sequencer state encoding, the machine word width and the default memory depths.
// No logic lives here; it is imported by the responder and its RAM sub-module.
package mips_mem_pkg;

  localparam int WORD_W          = 32;
  localparam int IMEM_WORDS_DEF  = 256;
  localparam int DMEM_WORDS_DEF  = 256;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mips_mem_responder_word_ram.sv
// word_ram: DEPTH x 32-bit storage, one synchronous write port, one asynchronous read port.
// Latency: a write lands at the rising clk edge; the read port reflects it in the next cycle.
// Backpressure: none, every write and read is accepted unconditionally.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (combinational read port).
module word_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  // Contents deliberately have no reset: program and data survive a responder reset.
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Instruction/data memory responder for a MIPS core, with a boot loader that fills IMEM first.
// Latency: fetch and load data are combinational; stores and boot words commit at the rising clk edge.
// Backpressure: ld_ready is high for the whole LOAD phase; the CPU side is never stalled.
// Ports: clk/rst; inst_adr->inst fetch; data_adr/data_out/MemRead/MemWrite->data_in data access;
//        ld_valid/ld_data/ld_last/ld_ready boot stream; cpu_rst holds the CPU; mem_err sticky error.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] inst_adr,
  output logic [WORD_W-1:0] inst,
  input  logic [WORD_W-1:0] data_adr,
  input  logic [WORD_W-1:0] data_out,
  output logic [WORD_W-1:0] data_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic              mem_err
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  state_t            state;
  logic [IAW-1:0]    ptr;

  logic              run;
  logic              ld_fire;
  logic              inst_ok;
  logic              data_ok;
  logic              data_acc;
  logic              err_set;
  logic              dmem_we;
  logic [WORD_W-1:0] imem_rdata;
  logic [WORD_W-1:0] dmem_rdata;

  assign run      = (state == RUN);
  assign ld_ready = (state == LOAD);
  assign cpu_rst  = (state == LOAD);
  assign ld_fire  = ld_valid && ld_ready;

  // In range means every address bit above the word index is zero; aligned means byte offset 0.
  assign inst_ok  = ((inst_adr >> (IAW + 2)) == '0) && (inst_adr[1:0] == 2'b00);
  assign data_ok  = ((data_adr >> (DAW + 2)) == '0) && (data_adr[1:0] == 2'b00);
  assign data_acc = MemRead || MemWrite;

  // Fetch is continuous in RUN, so a bad inst_adr flags an error even without a strobe.
  assign err_set  = run && ((data_acc && !data_ok) || !inst_ok);
  assign dmem_we  = run && MemWrite && data_ok;

  // During a simultaneous read+write the async read still sees the old word this cycle.
  assign inst     = (run && inst_ok)            ? imem_rdata : '0;
  assign data_in  = (run && MemRead && data_ok) ? dmem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      ptr     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_fire) begin
            ptr <= ptr + 1'b1;
            // A full IMEM ends the load even without ld_last, so the pointer never wraps onto word 0.
            if (ld_last || (&ptr)) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (err_set) begin
            mem_err <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  word_ram #(.DEPTH(IMEM_WORDS)) u_imem (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (ptr),
    .wdata (ld_data),
    .raddr (inst_adr[IAW+1:2]),
    .rdata (imem_rdata)
  );

  word_ram #(.DEPTH(DMEM_WORDS)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (data_adr[DAW+1:2]),
    .wdata (data_out),
    .raddr (data_adr[DAW+1:2]),
    .rdata (dmem_rdata)
  );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed testbench for mips_mem_responder: boot load, abort/reload, data access vectors, error flag.
// Inputs change on the falling edge; outputs are compared 1 ns later, well away from the rising edge.
// All expected values are hand-computed constants held in the bench.
module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_adr;
  logic [31:0] inst;
  logic [31:0] data_adr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        MemRead;
  logic        MemWrite;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_rst;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .inst_adr (inst_adr),
    .inst     (inst),
    .data_adr (data_adr),
    .data_out (data_out),
    .data_in  (data_in),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .mem_err  (mem_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
  endtask

  typedef struct {
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dout;
    logic        rd;
    logic        wr;
    logic        lv;
    logic [31:0] ld;
    logic [31:0] exp_inst;
    logic [31:0] exp_din;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // Each row is one cycle in RUN; exp_err is the flag value before that cycle's edge.
    vecs[0]  = '{32'h0, 32'h10,  32'hDEADBEEF, 0, 1, 0, 32'h0,        32'h20080005, 32'h0,        0};
    vecs[1]  = '{32'h4, 32'h10,  32'h0,        1, 0, 1, 32'hFFFFFFFF, 32'h20090007, 32'hDEADBEEF, 0};
    vecs[2]  = '{32'h0, 32'h10,  32'h0,        1, 0, 0, 32'h0,        32'h20080005, 32'hDEADBEEF, 0};
    vecs[3]  = '{32'hC, 32'h10,  32'h12345678, 1, 1, 0, 32'h0,        32'hAC0A0000, 32'hDEADBEEF, 0};
    vecs[4]  = '{32'h8, 32'h10,  32'h0,        1, 0, 0, 32'h0,        32'h01095020, 32'h12345678, 0};
    vecs[5]  = '{32'h0, 32'h14,  32'hCAFEF00D, 0, 1, 0, 32'h0,        32'h20080005, 32'h0,        0};
    vecs[6]  = '{32'h0, 32'h14,  32'h0,        1, 0, 0, 32'h0,        32'h20080005, 32'hCAFEF00D, 0};
    vecs[7]  = '{32'h0, 32'h10,  32'h0,        0, 0, 0, 32'h0,        32'h20080005, 32'h0,        0};
    vecs[8]  = '{32'h4, 32'h13,  32'hBAD0BAD0, 0, 1, 0, 32'h0,        32'h20090007, 32'h0,        0};
    vecs[9]  = '{32'h4, 32'h10,  32'h0,        1, 0, 0, 32'h0,        32'h20090007, 32'h12345678, 1};
    vecs[10] = '{32'h0, 32'h400, 32'h0,        1, 0, 0, 32'h0,        32'h20080005, 32'h0,        1};
    vecs[11] = '{32'h0, 32'h12,  32'h0,        1, 0, 0, 32'h0,        32'h20080005, 32'h0,        1};

    rst = 1'b1; inst_adr = '0; data_adr = '0; data_out = '0;
    MemRead = 1'b0; MemWrite = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; MemRead = 1'b1; data_adr = 32'h10;
    #1;
    check("reset_cpu_rst",  {31'b0, cpu_rst},  32'h1);
    check("reset_ld_ready", {31'b0, ld_ready}, 32'h1);
    check("reset_mem_err",  {31'b0, mem_err},  32'h0);
    check("load_inst_zero", inst,    32'h0);
    check("load_din_zero",  data_in, 32'h0);
    MemRead = 1'b0;

    // Aborted load: two junk words, then reset mid-load.
    load_word(32'hAAAA0000, 1'b0);
    load_word(32'hAAAA0001, 1'b0);
    @(negedge clk);
    ld_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midload_rst_cpu_rst",  {31'b0, cpu_rst},  32'h1);
    check("midload_rst_ld_ready", {31'b0, ld_ready}, 32'h1);

    // Real program; ld_last on the fourth word.
    load_word(32'h20080005, 1'b0);
    load_word(32'h20090007, 1'b0);
    load_word(32'h01095020, 1'b0);
    load_word(32'hAC0A0000, 1'b1);
    #1;
    check("last_word_cpu_rst_still_high", {31'b0, cpu_rst}, 32'h1);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0; inst_adr = 32'h8;
    #1;
    check("run_cpu_rst_low",  {31'b0, cpu_rst},  32'h0);
    check("run_ld_ready_low", {31'b0, ld_ready}, 32'h0);
    check("inst_at_8",        inst, 32'h01095020);
    inst_adr = 32'h0;
    #1;
    check("inst_at_0_ptr_reset", inst, 32'h20080005);
    inst_adr = 32'h2;
    #1;
    check("inst_misaligned_zero", inst, 32'h0);
    inst_adr = 32'h0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      inst_adr = vecs[i].ia; data_adr = vecs[i].da; data_out = vecs[i].dout;
      MemRead = vecs[i].rd; MemWrite = vecs[i].wr;
      ld_valid = vecs[i].lv; ld_data = vecs[i].ld;
      #1;
      check($sformatf("vec%0d_inst", i),     inst,    vecs[i].exp_inst);
      check($sformatf("vec%0d_data_in", i),  data_in, vecs[i].exp_din);
      check($sformatf("vec%0d_mem_err", i),  {31'b0, mem_err},  {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_ld_ready", i), {31'b0, ld_ready}, 32'h0);
    end

    // Reset during RUN clears the error and returns to LOAD.
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; ld_valid = 1'b0; rst = 1'b1; inst_adr = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("runrst_mem_err", {31'b0, mem_err}, 32'h0);
    check("runrst_cpu_rst", {31'b0, cpu_rst}, 32'h1);

    // Full reload without ld_last; CPU strobes during LOAD must be ignored.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_data = 32'h10000000 + 32'(i); ld_last = 1'b0;
      MemRead = 1'b0; MemWrite = 1'b0;
      if (i == 10) begin
        MemRead = 1'b1; MemWrite = 1'b1; data_adr = 32'h14; data_out = 32'h55555555;
      end else if (i == 11) begin
        MemRead = 1'b1; data_adr = 32'h13;
      end
      #1;
      if (i == 10) check("load_strobe_din_zero", data_in, 32'h0);
      if (i == 255) check("word256_cpu_rst_still_high", {31'b0, cpu_rst}, 32'h1);
    end
    // Extra offered word after the 256th must not wrap onto IMEM[0].
    @(negedge clk);
    ld_data = 32'hEEEEEEEE; MemRead = 1'b0;
    #1;
    check("full_load_cpu_rst_low",  {31'b0, cpu_rst},  32'h0);
    check("full_load_ld_ready_low", {31'b0, ld_ready}, 32'h0);
    check("load_strobes_no_err",    {31'b0, mem_err},  32'h0);
    @(negedge clk);
    ld_valid = 1'b0; inst_adr = 32'h0;
    #1;
    check("reload_inst_0_no_wrap", inst, 32'h10000000);
    inst_adr = 32'h3FC;
    #1;
    check("reload_inst_last", inst, 32'h100000FF);
    inst_adr = 32'h0; MemRead = 1'b1; data_adr = 32'h10;
    #1;
    check("dmem_retained_0x10", data_in, 32'h12345678);
    data_adr = 32'h14;
    #1;
    check("dmem_load_write_ignored", data_in, 32'hCAFEF00D);
    @(negedge clk);
    MemRead = 1'b0; inst_adr = 32'h400;
    #1;
    check("inst_out_of_range_zero", inst, 32'h0);
    check("err_before_bad_fetch_edge", {31'b0, mem_err}, 32'h0);
    @(negedge clk);
    inst_adr = 32'h0;
    #1;
    check("bad_fetch_sets_err", {31'b0, mem_err}, 32'h1);
    check("inst_after_bad_fetch", inst, 32'h10000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
